pkt_hdr_parser: RTL and testbench
=================================

# pkt_hdr_parser

Parses the first 512-bit beat of each AXI-stream packet in the box_250mhz p2p datapath. Extracts the Ethernet, IPv4/IPv6 and TCP/UDP header fields defined in packet_pkg. Forwards the stream through a one-stage register slice with the parsed fields as beat-aligned sideband. Feeds the downstream flow classifier/match stage and keeps per-class packet counters.

## Interface
- DATA_W, 512, stream width; only 512 is supported (the whole L2–L4 header must fit in beat 0).
- CNT_W, 32, statistics counter width.

Ports:
- axis_aclk  in  1  clock (250 MHz)
- axis_rst  in  1  reset; synchronous, active-high; one clock, no other clock or reset
- s_axis_tvalid  in  1  input beat valid
- s_axis_tdata  in  512  big-endian; byte b at bits [511-8b -: 8]
- s_axis_tkeep  in  64  byte enables; bit 63 = byte 0; contiguous from byte 0
- s_axis_tlast  in  1  last beat
- s_axis_tuser_size  in  16  packet length in bytes; valid on the first beat
- s_axis_tready  out  1  input ready
- m_axis_tvalid / tdata / tkeep / tlast / tuser_size  out  1/512/64/1/16  registered copy of the input
- m_axis_tready  in  1  downstream ready
- m_hdr_sop  out  1  current output beat is the first of its packet
- m_hdr_l3  out  2  0 = other, 1 = IPv4, 2 = IPv6
- m_hdr_proto  out  8  IPv4 protocol / IPv6 next header; 0 if l3 = other
- m_hdr_l4_valid  out  1  proto is TCP (6) or UDP (17) and the port fields are valid
- m_hdr_src_ip, m_hdr_dst_ip  out  128 each  IPv6 address, or IPv4 address in [31:0] with [127:32] = 0
- m_hdr_src_port, m_hdr_dst_port  out  16 each  L4 ports; 0 unless l4_valid
- m_hdr_runt  out  1  first beat too short for the header that eth_type announces
- stat_clr  in  1  synchronous clear of all counters
- stat_pkt_cnt, stat_ipv4_cnt, stat_ipv6_cnt, stat_runt_cnt  out  CNT_W each

## Operation
- **SOP tracking:** flag `in_sop`, reset to 1.
  - Cleared on an input handshake with tlast = 0.
  - Set on an input handshake with tlast = 1.
- **Parse on an input handshake with in_sop = 1.** Valid bytes n = popcount(tkeep).
- **eth_type** is bytes 12–13. If n < 14, then l3 = other and runt = 1.
- **IPv4 (eth_type 0x0800):**
  - Fields: proto = byte 23, src = bytes 26–29, dst = bytes 30–33.
  - Runt if n < 34.
  - l4_valid requires: IHL (byte 14 [3:0]) == 5, flags/frag_offset[12:0] == 0, proto ∈ {6, 17}, and n ≥ 38.
  - Ports: src = bytes 34–35, dst = bytes 36–37.
  - IHL ≠ 5 or a fragment gives l4_valid = 0, not runt.
- **IPv6 (eth_type 0x86DD):**
  - Fields: next header = byte 20, src = bytes 22–37, dst = bytes 38–53.
  - Runt if n < 54.
  - l4_valid requires proto ∈ {6, 17} and n ≥ 58. Ports: bytes 54–57.
  - Extension headers are not followed.
- **Any other eth_type:** l3 = other; all fields 0.
- **Runt packets:** l3 = other, l4_valid = 0, and all address and port fields are 0.
- **Field hold:** parsed fields are registered with beat 0 and held unchanged on m_hdr_* for every beat of the packet. m_hdr_sop is 1 only on beat 0.
- **Counters** increment on the output-side first-beat handshake (m_axis_tvalid & m_axis_tready & m_hdr_sop):
  - pkt always; ipv4/ipv6 by l3; runt by runt.
  - Counters wrap modulo 2^CNT_W.
  - stat_clr has priority over a same-cycle increment (the counter becomes 0).
- **Pass-through:** tdata/tkeep/tlast/tuser_size are unmodified.

## Timing
- **Register slice:** s_axis_tready = !m_axis_tvalid | m_axis_tready.
  - Latency: 1 cycle. Full throughput: one beat per cycle with downstream always ready.
- **Handshake rules:** m_axis_* and m_hdr_* are stable while m_axis_tvalid = 1 and m_axis_tready = 0. m_axis_tvalid never drops without a handshake.
- **Simultaneous events:** an output handshake and an input handshake in the same cycle load the new beat with no bubble.
- **Reset values:** m_axis_tvalid = 0, all m_axis_* data = 0, in_sop = 1, all m_hdr_* = 0, counters = 0, s_axis_tready = 1 from the first cycle after reset.
- **Reset mid-packet:** the in-flight beat is dropped. The next input beat is treated as SOP.
- **Single-beat packet:** m_hdr_sop = 1 and m_axis_tlast = 1 on the same beat.

## Test plan
- **IPv4 TCP, 1 beat, n = 64:**
  - Stimulus: dst_mac ff..ff, eth_type 0x0800, IHL 5, proto 6, src 10.0.0.1, dst 10.0.0.2, ports 1234→80.
  - Response: one cycle later l3 = 1, proto = 0x06, src_ip = 0x0A000001, dst_ip = 0x0A000002, ports 0x04D2/0x0050, l4_valid = 1, stat_ipv4_cnt = 1.
- **IPv6 UDP, 3 beats:**
  - Stimulus: next header 17, src 2001:db8::1, dst 2001:db8::2, ports 53→5353.
  - Response: l3 = 2, l4_valid = 1, fields identical on all 3 output beats, m_hdr_sop only on beat 0, stat_ipv6_cnt = 1.
- **IPv4 with IHL 6, and IPv4 with frag_offset 1:**
  - Response: l3 = 1, l4_valid = 0, ports 0, runt = 0.
- **Runts:**
  - IPv6 packet with n = 40, tlast = 1: response runt = 1, l3 = 0, stat_runt_cnt = 1.
  - eth_type 0x0806 ARP with n = 60: response l3 = 0, runt = 0.
- **Backpressure:**
  - Stimulus: random m_axis_tready (50%) over 100 back-to-back mixed packets.
  - Response: output stream bit-exact to input, no beat lost or duplicated, outputs stable while stalled, stat_pkt_cnt = 100.
- **Reset and counter clear:**
  - Stimulus: axis_rst asserted mid-packet, then a new packet is sent.
  - Response: that packet's beat 0 is parsed as SOP; all outputs 0 the cycle after reset.
  - Stimulus: stat_clr asserted in the same cycle as an SOP handshake.
  - Response: counters read 0.

Source files
------------

// File: rtl/pkt_hdr_parser.sv
// pkt_hdr_parser: one-stage AXI-stream slice that parses L2-L4 headers from beat 0 and counts packet classes
module pkt_hdr_parser #(
  parameter int DATA_W = 512,
  parameter int CNT_W = 32
) (
  input  logic                  axis_aclk,
  input  logic                  axis_rst,
  input  logic                  s_axis_tvalid,
  input  logic [DATA_W-1:0]     s_axis_tdata,
  input  logic [DATA_W/8-1:0]   s_axis_tkeep,
  input  logic                  s_axis_tlast,
  input  logic [15:0]           s_axis_tuser_size,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [DATA_W-1:0]     m_axis_tdata,
  output logic [DATA_W/8-1:0]   m_axis_tkeep,
  output logic                  m_axis_tlast,
  output logic [15:0]           m_axis_tuser_size,
  input  logic                  m_axis_tready,
  output logic                  m_hdr_sop,
  output logic [1:0]            m_hdr_l3,
  output logic [7:0]            m_hdr_proto,
  output logic                  m_hdr_l4_valid,
  output logic [127:0]          m_hdr_src_ip,
  output logic [127:0]          m_hdr_dst_ip,
  output logic [15:0]           m_hdr_src_port,
  output logic [15:0]           m_hdr_dst_port,
  output logic                  m_hdr_runt,
  input  logic                  stat_clr,
  output logic [CNT_W-1:0]      stat_pkt_cnt,
  output logic [CNT_W-1:0]      stat_ipv4_cnt,
  output logic [CNT_W-1:0]      stat_ipv6_cnt,
  output logic [CNT_W-1:0]      stat_runt_cnt
);
  logic [6:0] n;
  logic [15:0] eth;
  logic is4, is6, v4, v6;
  logic p_runt, p_l4;
  logic [1:0] p_l3;
  logic [7:0] p_proto;
  logic [127:0] p_sip, p_dip;
  logic [15:0] p_sp, p_dp;
  logic in_hs, ld, cnt_en;
  logic in_sop_q, in_sop_d;
  logic tvalid_q, tvalid_d;
  logic [DATA_W-1:0] tdata_q, tdata_d;
  logic [DATA_W/8-1:0] tkeep_q, tkeep_d;
  logic tlast_q, tlast_d;
  logic [15:0] tsize_q, tsize_d;
  logic sop_q, sop_d;
  logic [1:0] l3_q, l3_d;
  logic [7:0] proto_q, proto_d;
  logic l4_q, l4_d;
  logic [127:0] sip_q, sip_d, dip_q, dip_d;
  logic [15:0] sp_q, sp_d, dp_q, dp_d;
  logic runt_q, runt_d;
  logic [CNT_W-1:0] pkt_q, pkt_d, v4c_q, v4c_d, v6c_q, v6c_d, rntc_q, rntc_d;

  assign s_axis_tready = !tvalid_q | m_axis_tready;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata = tdata_q;
  assign m_axis_tkeep = tkeep_q;
  assign m_axis_tlast = tlast_q;
  assign m_axis_tuser_size = tsize_q;
  assign m_hdr_sop = sop_q;
  assign m_hdr_l3 = l3_q;
  assign m_hdr_proto = proto_q;
  assign m_hdr_l4_valid = l4_q;
  assign m_hdr_src_ip = sip_q;
  assign m_hdr_dst_ip = dip_q;
  assign m_hdr_src_port = sp_q;
  assign m_hdr_dst_port = dp_q;
  assign m_hdr_runt = runt_q;
  assign stat_pkt_cnt = pkt_q;
  assign stat_ipv4_cnt = v4c_q;
  assign stat_ipv6_cnt = v6c_q;
  assign stat_runt_cnt = rntc_q;

  always_comb begin
    n = 7'($countones(s_axis_tkeep));
    eth = s_axis_tdata[415:400];
    is4 = eth == 16'h0800;
    is6 = eth == 16'h86DD;
    p_runt = n < 7'd14 || (is4 && n < 7'd34) || (is6 && n < 7'd54);
    p_l3 = p_runt ? 2'd0 : is4 ? 2'd1 : is6 ? 2'd2 : 2'd0;
    v4 = p_l3 == 2'd1;
    v6 = p_l3 == 2'd2;
    p_proto = v4 ? s_axis_tdata[327:320] : v6 ? s_axis_tdata[351:344] : 8'd0;
    p_l4 = (p_proto == 8'd6 || p_proto == 8'd17) &&
           (v4 ? (s_axis_tdata[395:392] == 4'd5 && s_axis_tdata[348:336] == 13'd0 && n >= 7'd38)
               : (v6 && n >= 7'd58));
    p_sip = v4 ? {96'd0, s_axis_tdata[303:272]} : v6 ? s_axis_tdata[335:208] : '0;
    p_dip = v4 ? {96'd0, s_axis_tdata[271:240]} : v6 ? s_axis_tdata[207:80] : '0;
    p_sp = !p_l4 ? 16'd0 : v4 ? s_axis_tdata[239:224] : s_axis_tdata[79:64];
    p_dp = !p_l4 ? 16'd0 : v4 ? s_axis_tdata[223:208] : s_axis_tdata[63:48];
  end

  always_comb begin
    in_hs = s_axis_tvalid & s_axis_tready;
    ld = in_hs & in_sop_q;
    in_sop_d = in_hs ? s_axis_tlast : in_sop_q;
    tvalid_d = in_hs | (tvalid_q & !m_axis_tready);
    tdata_d = in_hs ? s_axis_tdata : tdata_q;
    tkeep_d = in_hs ? s_axis_tkeep : tkeep_q;
    tlast_d = in_hs ? s_axis_tlast : tlast_q;
    tsize_d = in_hs ? s_axis_tuser_size : tsize_q;
    sop_d = in_hs ? in_sop_q : sop_q;
    l3_d = ld ? p_l3 : l3_q;
    proto_d = ld ? p_proto : proto_q;
    l4_d = ld ? p_l4 : l4_q;
    sip_d = ld ? p_sip : sip_q;
    dip_d = ld ? p_dip : dip_q;
    sp_d = ld ? p_sp : sp_q;
    dp_d = ld ? p_dp : dp_q;
    runt_d = ld ? p_runt : runt_q;
  end

  always_comb begin
    cnt_en = tvalid_q & m_axis_tready & sop_q;
    pkt_d = stat_clr ? '0 : pkt_q + CNT_W'(cnt_en);
    v4c_d = stat_clr ? '0 : v4c_q + CNT_W'(cnt_en && l3_q == 2'd1);
    v6c_d = stat_clr ? '0 : v6c_q + CNT_W'(cnt_en && l3_q == 2'd2);
    rntc_d = stat_clr ? '0 : rntc_q + CNT_W'(cnt_en && runt_q);
  end

  always_ff @(posedge axis_aclk) begin
    if (axis_rst) begin
      in_sop_q <= 1'b1;
      tvalid_q <= 1'b0;
      tdata_q <= '0;
      tkeep_q <= '0;
      tlast_q <= 1'b0;
      tsize_q <= '0;
      sop_q <= 1'b0;
      l3_q <= '0;
      proto_q <= '0;
      l4_q <= 1'b0;
      sip_q <= '0;
      dip_q <= '0;
      sp_q <= '0;
      dp_q <= '0;
      runt_q <= 1'b0;
      pkt_q <= '0;
      v4c_q <= '0;
      v6c_q <= '0;
      rntc_q <= '0;
    end else begin
      in_sop_q <= in_sop_d;
      tvalid_q <= tvalid_d;
      tdata_q <= tdata_d;
      tkeep_q <= tkeep_d;
      tlast_q <= tlast_d;
      tsize_q <= tsize_d;
      sop_q <= sop_d;
      l3_q <= l3_d;
      proto_q <= proto_d;
      l4_q <= l4_d;
      sip_q <= sip_d;
      dip_q <= dip_d;
      sp_q <= sp_d;
      dp_q <= dp_d;
      runt_q <= runt_d;
      pkt_q <= pkt_d;
      v4c_q <= v4c_d;
      v6c_q <= v6c_d;
      rntc_q <= rntc_d;
    end
  end
endmodule

// File: tb/tb_pkt_hdr_parser.sv
// tb_pkt_hdr_parser: directed and backpressure checks of the header parser slice
module tb_pkt_hdr_parser;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;

  logic s_valid = 0, s_last = 0, m_ready = 1, stat_clr = 0;
  logic [511:0] s_data = '0;
  logic [63:0] s_keep = '0;
  logic [15:0] s_size = '0;
  logic s_tready, m_tvalid, m_tlast, m_sop, m_l4, m_runt;
  logic [511:0] m_tdata;
  logic [63:0] m_tkeep;
  logic [15:0] m_tsize, m_sp, m_dp;
  logic [1:0] m_l3;
  logic [7:0] m_proto;
  logic [127:0] m_sip, m_dip;
  logic [31:0] c_pkt, c_v4, c_v6, c_runt;

  typedef struct packed {
    logic [511:0] d;
    logic [63:0] k;
    logic l;
    logic [15:0] sz;
    logic sop;
    logic [1:0] l3;
    logic [7:0] proto;
    logic l4;
    logic [127:0] sip;
    logic [127:0] dip;
    logic [15:0] sp;
    logic [15:0] dp;
    logic runt;
  } beat_t;

  beat_t snap;
  assign snap = {m_tdata, m_tkeep, m_tlast, m_tsize, m_sop, m_l3, m_proto, m_l4, m_sip, m_dip, m_sp, m_dp, m_runt};

  pkt_hdr_parser dut (
    .axis_aclk(clk), .axis_rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tdata(s_data), .s_axis_tkeep(s_keep),
    .s_axis_tlast(s_last), .s_axis_tuser_size(s_size), .s_axis_tready(s_tready),
    .m_axis_tvalid(m_tvalid), .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep),
    .m_axis_tlast(m_tlast), .m_axis_tuser_size(m_tsize), .m_axis_tready(m_ready),
    .m_hdr_sop(m_sop), .m_hdr_l3(m_l3), .m_hdr_proto(m_proto), .m_hdr_l4_valid(m_l4),
    .m_hdr_src_ip(m_sip), .m_hdr_dst_ip(m_dip), .m_hdr_src_port(m_sp), .m_hdr_dst_port(m_dp),
    .m_hdr_runt(m_runt), .stat_clr(stat_clr),
    .stat_pkt_cnt(c_pkt), .stat_ipv4_cnt(c_v4), .stat_ipv6_cnt(c_v6), .stat_runt_cnt(c_runt)
  );

  localparam logic [127:0] V6S = 128'h20010db8000000000000000000000001;
  localparam logic [127:0] V6D = 128'h20010db8000000000000000000000002;

  int checks = 0, failures = 0;
  logic [31:0] exp_pkt = 0, exp_v4 = 0, exp_v6 = 0, exp_runt = 0;
  logic [7:0] pb [192];
  beat_t q [$];
  logic drv_done = 0, done = 0;

  task automatic fill_rand();
    for (int i = 0; i < 192; i++) pb[i] = 8'($urandom);
  endtask

  task automatic put(input int off, input int nb, input logic [127:0] v);
    for (int i = 0; i < nb; i++) pb[off + i] = v[8 * (nb - 1 - i) +: 8];
  endtask

  task automatic mk_v4(input logic [3:0] ihl, input logic [15:0] frag, input logic [7:0] proto);
    put(0, 6, 128'hFFFFFFFFFFFF);
    put(12, 2, 128'h0800);
    pb[14] = {4'h4, ihl};
    put(20, 2, {112'd0, frag});
    pb[23] = proto;
    put(26, 4, 128'h0A000001);
    put(30, 4, 128'h0A000002);
    put(34, 2, 128'd1234);
    put(36, 2, 128'd80);
  endtask

  task automatic mk_v6(input logic [7:0] nh);
    put(12, 2, 128'h86DD);
    pb[14] = 8'h60;
    pb[20] = nh;
    put(22, 16, V6S);
    put(38, 16, V6D);
    put(54, 2, 128'd53);
    put(56, 2, 128'd5353);
  endtask

  task automatic mk_t(input int t);
    if (t == 0) mk_v4(4'd5, 16'd0, 8'd6);
    else if (t == 1) mk_v6(8'd17);
    else if (t == 2) put(12, 2, 128'h0806);
    else mk_v4(4'd5, 16'd0, 8'd1);
  endtask

  function automatic logic [511:0] bd(input int b);
    logic [511:0] r;
    for (int i = 0; i < 64; i++) r[511 - 8 * i -: 8] = pb[64 * b + i];
    return r;
  endfunction

  function automatic logic [63:0] kp(input int n);
    return ~(64'hFFFF_FFFF_FFFF_FFFF >> n);
  endfunction

  function automatic beat_t eh(input logic [1:0] l3, input logic [7:0] proto, input logic l4, input logic runt);
    beat_t e;
    e = '0;
    e.l3 = l3;
    e.proto = proto;
    e.l4 = l4;
    e.runt = runt;
    if (l3 == 2'd1) begin
      e.sip = 128'h0A000001;
      e.dip = 128'h0A000002;
      if (l4) begin e.sp = 16'd1234; e.dp = 16'd80; end
    end
    if (l3 == 2'd2) begin
      e.sip = V6S;
      e.dip = V6D;
      if (l4) begin e.sp = 16'd53; e.dp = 16'd5353; end
    end
    return e;
  endfunction

  function automatic beat_t eh_t(input int t);
    return t == 0 ? eh(2'd1, 8'd6, 1'b1, 1'b0) : t == 1 ? eh(2'd2, 8'd17, 1'b1, 1'b0) : eh(2'd0, 8'd0, 1'b0, 1'b0);
  endfunction

  function automatic beat_t eb(input beat_t h, input int b, input int n, input logic l, input logic [15:0] sz);
    beat_t e;
    e = h;
    e.d = bd(b);
    e.k = kp(n);
    e.l = l;
    e.sz = sz;
    e.sop = b == 0;
    return e;
  endfunction

  // called at a negedge; returns just after the posedge that completes the handshake
  task automatic send(input logic [511:0] d, input logic [63:0] k, input logic l, input logic [15:0] sz);
    logic ok;
    ok = 0;
    s_valid = 1;
    s_data = d;
    s_keep = k;
    s_last = l;
    s_size = sz;
    for (int i = 0; i < 1000 && !ok; i++) begin
      ok = s_tready;
      @(posedge clk);
      if (!ok) @(negedge clk);
    end
    checks++;
    if (!ok) begin failures++; $display("FAIL send_timeout got=no_ready exp=ready"); end
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_tvalid, snap} !== '0) begin failures++; $display("FAIL reset_out got=%h exp=0", {m_tvalid, snap}); end
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== '0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", {c_pkt, c_v4, c_v6, c_runt}); end
    checks++;
    if (s_tready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", s_tready); end
    rst = 0;
  endtask

  task automatic test_ipv4_tcp();
    beat_t e;
    fill_rand();
    mk_t(0);
    e = eb(eh_t(0), 0, 64, 1'b1, 16'd64);
    send(bd(0), kp(64), 1'b1, 16'd64);
    @(negedge clk);
    s_valid = 0;
    checks++;
    if ({m_tvalid, snap} !== {1'b1, e}) begin failures++; $display("FAIL ipv4_tcp got=%h exp=%h", snap, e); end
    @(posedge clk);
    @(negedge clk);
    exp_pkt++;
    exp_v4++;
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL ipv4_tcp_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_ipv6_udp();
    beat_t e;
    int n;
    fill_rand();
    mk_t(1);
    for (int b = 0; b < 3; b++) begin
      n = b == 2 ? 22 : 64;
      e = eb(eh_t(1), b, n, b == 2, 16'd150);
      send(bd(b), kp(n), b == 2, 16'd150);
      @(negedge clk);
      checks++;
      if ({m_tvalid, snap} !== {1'b1, e}) begin failures++; $display("FAIL ipv6_udp_beat%0d got=%h exp=%h", b, snap, e); end
    end
    s_valid = 0;
    @(posedge clk);
    @(negedge clk);
    exp_pkt++;
    exp_v6++;
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL ipv6_udp_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_ipv4_nol4();
    logic [3:0] ihl [3] = '{4'd6, 4'd5, 4'd5};
    logic [15:0] frag [3] = '{16'h0000, 16'h0001, 16'h4000};
    logic l4 [3] = '{1'b0, 1'b0, 1'b1};
    beat_t e;
    for (int i = 0; i < 3; i++) begin
      fill_rand();
      mk_v4(ihl[i], frag[i], 8'd6);
      e = eb(eh(2'd1, 8'd6, l4[i], 1'b0), 0, 64, 1'b1, 16'd64);
      send(bd(0), kp(64), 1'b1, 16'd64);
      @(negedge clk);
      checks++;
      if ({m_tvalid, snap} !== {1'b1, e}) begin failures++; $display("FAIL ipv4_nol4_%0d got=%h exp=%h", i, snap, e); end
      exp_pkt++;
      exp_v4++;
    end
    s_valid = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL ipv4_nol4_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_runt_boundary();
    int tt [11] = '{1, 2, 0, 0, 0, 0, 0, 1, 1, 1, 3};
    int nn [11] = '{40, 60, 13, 33, 34, 37, 38, 53, 54, 58, 64};
    int l3 [11] = '{0, 0, 0, 0, 1, 1, 1, 0, 2, 2, 1};
    int pr [11] = '{0, 0, 0, 0, 6, 6, 6, 0, 17, 17, 1};
    int l4 [11] = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0};
    int rn [11] = '{1, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0};
    beat_t e;
    for (int i = 0; i < 11; i++) begin
      fill_rand();
      mk_t(tt[i]);
      e = eb(eh(2'(l3[i]), 8'(pr[i]), 1'(l4[i]), 1'(rn[i])), 0, nn[i], 1'b1, 16'(nn[i]));
      send(bd(0), kp(nn[i]), 1'b1, 16'(nn[i]));
      @(negedge clk);
      checks++;
      if ({m_tvalid, snap} !== {1'b1, e}) begin failures++; $display("FAIL runt_bound_%0d got=%h exp=%h", i, snap, e); end
      exp_pkt++;
      if (l3[i] == 1) exp_v4++;
      if (l3[i] == 2) exp_v6++;
      if (rn[i] == 1) exp_runt++;
    end
    s_valid = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL runt_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_back_to_back();
    beat_t e;
    for (int t = 0; t < 3; t++) begin
      fill_rand();
      mk_t(t);
      e = eb(eh_t(t), 0, 64, 1'b1, 16'd64);
      send(bd(0), kp(64), 1'b1, 16'd64);
      @(negedge clk);
      checks++;
      if ({s_tready, m_tvalid, snap} !== {2'b11, e}) begin failures++; $display("FAIL b2b_%0d got=%h exp=%h", t, snap, e); end
    end
    s_valid = 0;
    @(posedge clk);
    @(negedge clk);
    exp_pkt += 3;
    exp_v4++;
    exp_v6++;
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL b2b_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_backpressure();
    drv_done = 0;
    done = 0;
    fork
      begin
        int t, nb, n;
        beat_t h;
        for (int p = 0; p < 100; p++) begin
          t = p % 3;
          nb = 1 + $urandom_range(0, 2);
          n = nb == 1 ? 64 : $urandom_range(1, 64);
          fill_rand();
          mk_t(t);
          h = eh_t(t);
          exp_pkt++;
          if (t == 0) exp_v4++;
          if (t == 1) exp_v6++;
          for (int b = 0; b < nb; b++) q.push_back(eb(h, b, b == nb - 1 ? n : 64, b == nb - 1, 16'(64 * (nb - 1) + n)));
          for (int b = 0; b < nb; b++) begin
            @(negedge clk);
            send(bd(b), kp(b == nb - 1 ? n : 64), b == nb - 1, 16'(64 * (nb - 1) + n));
          end
        end
        @(negedge clk);
        s_valid = 0;
        drv_done = 1;
      end
      begin
        beat_t prev;
        logic stall;
        int cyc;
        stall = 0;
        prev = '0;
        cyc = 0;
        while (!(drv_done && q.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          if (stall) begin
            checks++;
            if ({m_tvalid, snap} !== {1'b1, prev}) begin failures++; $display("FAIL bp_stable got=%h exp=%h", snap, prev); end
          end
          if (m_tvalid && m_ready) begin
            checks++;
            if (q.size() == 0) begin failures++; $display("FAIL bp_extra got=%h exp=none", snap); end
            else begin
              if (snap !== q[0]) begin failures++; $display("FAIL bp_beat got=%h exp=%h", snap, q[0]); end
              void'(q.pop_front());
            end
          end
          stall = m_tvalid && !m_ready;
          prev = snap;
        end
        checks++;
        if (cyc >= 20000) begin failures++; $display("FAIL bp_timeout got=%0d exp=0 pending", q.size()); end
        done = 1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #2 m_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    @(negedge clk);
    m_ready = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL bp_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_reset_mid();
    beat_t e;
    m_ready = 0;
    fill_rand();
    mk_t(0);
    send(bd(0), kp(64), 1'b0, 16'd128);
    @(negedge clk);
    s_valid = 0;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({m_tvalid, snap, c_pkt, c_v4, c_v6, c_runt} !== '0) begin failures++; $display("FAIL rst_mid_out got=%h exp=0", {m_tvalid, snap}); end
    checks++;
    if (s_tready !== 1'b1) begin failures++; $display("FAIL rst_mid_ready got=%b exp=1", s_tready); end
    rst = 0;
    m_ready = 1;
    exp_pkt = 0;
    exp_v4 = 0;
    exp_v6 = 0;
    exp_runt = 0;
    fill_rand();
    mk_t(1);
    e = eb(eh_t(1), 0, 64, 1'b1, 16'd64);
    send(bd(0), kp(64), 1'b1, 16'd64);
    @(negedge clk);
    s_valid = 0;
    checks++;
    if ({m_tvalid, snap} !== {1'b1, e}) begin failures++; $display("FAIL rst_mid_sop got=%h exp=%h", snap, e); end
    @(posedge clk);
    @(negedge clk);
    exp_pkt++;
    exp_v6++;
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {exp_pkt, exp_v4, exp_v6, exp_runt})
      begin failures++; $display("FAIL rst_mid_cnt got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d", c_pkt, c_v4, c_v6, c_runt, exp_pkt, exp_v4, exp_v6, exp_runt); end
  endtask

  task automatic test_stat_clr();
    fill_rand();
    mk_t(0);
    send(bd(0), kp(64), 1'b1, 16'd64);
    @(negedge clk);
    s_valid = 0;
    stat_clr = 1;
    @(posedge clk);
    @(negedge clk);
    stat_clr = 0;
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== '0)
      begin failures++; $display("FAIL clr_cnt got=%0d/%0d/%0d/%0d exp=0/0/0/0", c_pkt, c_v4, c_v6, c_runt); end
    fill_rand();
    mk_t(1);
    send(bd(0), kp(40), 1'b1, 16'd40);
    @(negedge clk);
    s_valid = 0;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({c_pkt, c_v4, c_v6, c_runt} !== {32'd1, 32'd0, 32'd0, 32'd1})
      begin failures++; $display("FAIL clr_after_cnt got=%0d/%0d/%0d/%0d exp=1/0/0/1", c_pkt, c_v4, c_v6, c_runt); end
  endtask

  initial begin
    test_reset();
    test_ipv4_tcp();
    test_ipv6_udp();
    test_ipv4_nol4();
    test_runt_boundary();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_stat_clr();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
